// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Purpose  : Parametrised serial bit-pattern detector. Shifts enabled bits of
//            a serial stream into a history register and pulses dout when the
//            last PAT_W enabled bits equal a run-time loadable pattern.
//            Supports overlapping / non-overlapping detection and keeps a
//            saturating match counter with a sticky saturation flag.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-high reset
//            en        - din qualifier (bit sampled only when en=1)
//            din       - serial data bit
//            load      - load pat_in into the pattern register
//            pat_in    - new pattern value (MSB is the oldest bit)
//            overlap   - 1 = overlapping detection, 0 = non-overlapping
//            clr_cnt   - synchronous clear of match_cnt / cnt_sat
//            dout      - registered one-cycle match pulse
//            match_cnt - saturating match counter
//            cnt_sat   - sticky flag, set on a match while counter is full
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 4'b1011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               c_FILL_W  = $clog2(PAT_W + 1);
  localparam logic [c_FILL_W-1:0] c_FULL = c_FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  // ARMED means the history holds PAT_W valid bits; IDLE means it is filling.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PAT_W-1:0]    r_pat;
  logic [PAT_W-1:0]    r_hist;
  logic [PAT_W-1:0]    w_hist_nxt;
  logic [PAT_W-1:0]    w_shift;
  logic [c_FILL_W-1:0] r_fill;
  logic [c_FILL_W-1:0] w_fill_nxt;
  logic [c_FILL_W-1:0] w_fill_inc;
  logic                r_dout;
  logic                w_dout_nxt;
  logic                w_hit;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_sat;

  // --------------------------------------------------------------------------
  // State / history / fill registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_hist  <= '0;
      r_fill  <= '0;
      r_dout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and match logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_dout_nxt  = 1'b0;
    w_hit       = 1'b0;
    w_shift     = {r_hist[PAT_W-2:0], din};
    // Fill saturates at PAT_W; once ARMED the count is pinned at full.
    w_fill_inc  = (r_state == ARMED) ? c_FULL : (r_fill + c_FILL_W'(1));

    if (load) begin
      // A new pattern invalidates any partial progress.
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
      w_state_nxt = IDLE;
    end else if (en) begin
      w_hist_nxt = w_shift;
      w_hit      = (w_fill_inc == c_FULL) && (w_shift == r_pat);
      w_dout_nxt = w_hit;
      // Non-overlapping: keep the bits but mark them stale so the next
      // match needs PAT_W fresh bits.
      if (w_hit && !overlap) begin
        w_fill_nxt = '0;
      end else begin
        w_fill_nxt = w_fill_inc;
      end
      w_state_nxt = (w_fill_nxt == c_FULL) ? ARMED : IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Pattern register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat <= RST_PAT;
    end else if (load) begin
      r_pat <= pat_in;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating match counter; a clear beats a coincident hit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_hit) begin
      if (r_cnt != c_CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_sat <= 1'b1;
      end
    end
  end

  assign dout      = r_dout;
  assign match_cnt = r_cnt;
  assign cnt_sat   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detector_param
// Purpose  : Self-checking bench for seq_detector_param. Two instances:
//            dut  - defaults (PAT_W=4, CNT_W=8, pattern 1011)
//            dut2 - PAT_W=2, CNT_W=2, pattern 11 (counter saturation)
//            Directed steps followed by random traffic, each compared
//            against a queue-based reference model of the detector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // Default instance
  logic       en = 1'b0, din = 1'b0, load = 1'b0, overlap = 1'b1, clr_cnt = 1'b0;
  logic [3:0] pat_in = 4'b0;
  logic       dout;
  logic [7:0] match_cnt;
  logic       cnt_sat;

  // Small instance
  logic       en2 = 1'b0, din2 = 1'b0, load2 = 1'b0, overlap2 = 1'b1, clr2 = 1'b0;
  logic [1:0] pat_in2 = 2'b0;
  logic       dout2;
  logic [1:0] cnt2;
  logic       sat2;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state: valid enabled bits since the last invalidation.
  bit         q1[$];
  logic [3:0] m_pat1 = 4'b1011;
  int         m_cnt1 = 0;
  bit         m_sat1 = 0;
  bit         m_dout1 = 0;
  bit         q2[$];
  logic [1:0] m_pat2 = 2'b11;
  int         m_cnt2 = 0;
  bit         m_sat2 = 0;
  bit         m_dout2 = 0;

  bit s7 [7] = '{1, 0, 1, 1, 0, 1, 1};
  bit s4 [4] = '{1, 0, 1, 1};
  bit s0110 [4] = '{0, 1, 1, 0};

  seq_detector_param dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .load(load), .pat_in(pat_in),
    .overlap(overlap), .clr_cnt(clr_cnt), .dout(dout), .match_cnt(match_cnt),
    .cnt_sat(cnt_sat)
  );

  seq_detector_param #(.PAT_W(2), .CNT_W(2), .RST_PAT(2'b11)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .din(din2), .load(load2), .pat_in(pat_in2),
    .overlap(overlap2), .clr_cnt(clr2), .dout(dout2), .match_cnt(cnt2),
    .cnt_sat(sat2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q1.delete(); m_pat1 = 4'b1011; m_cnt1 = 0; m_sat1 = 0; m_dout1 = 0;
    q2.delete(); m_pat2 = 2'b11;   m_cnt2 = 0; m_sat2 = 0; m_dout2 = 0;
  endtask

  // One clock of the default instance (small instance idles).
  task automatic step1(input bit e, input bit d, input bit l, input logic [3:0] p,
                       input bit c, input string tag);
    logic [15:0] v;
    bit          hit;
    @(negedge clk);
    en = e; din = d; load = l; pat_in = p; clr_cnt = c;
    en2 = 1'b0; load2 = 1'b0; clr2 = 1'b0;
    hit = 0;
    if (l) begin
      m_pat1 = p; q1.delete();
    end else if (e) begin
      q1.push_back(d);
      if (q1.size() > 4) void'(q1.pop_front());
      v = '0;
      for (int i = 0; i < q1.size(); i++) v = {v[14:0], q1[i]};
      hit = (q1.size() == 4) && (v[3:0] == m_pat1);
      if (hit && !overlap) q1.delete();
    end
    m_dout1 = hit;
    if (c) begin
      m_cnt1 = 0; m_sat1 = 0;
    end else if (hit) begin
      if (m_cnt1 < 255) m_cnt1++; else m_sat1 = 1;
    end
    @(posedge clk); #1;
    chk({tag, "_dout"}, 32'(dout), 32'(m_dout1));
    chk({tag, "_cnt"}, 32'(match_cnt), 32'(m_cnt1));
    chk({tag, "_sat"}, 32'(cnt_sat), 32'(m_sat1));
  endtask

  // One clock of the small instance (default instance idles).
  task automatic step2(input bit e, input bit d, input bit l, input logic [1:0] p,
                       input bit c, input string tag);
    logic [15:0] v;
    bit          hit;
    @(negedge clk);
    en2 = e; din2 = d; load2 = l; pat_in2 = p; clr2 = c;
    en = 1'b0; load = 1'b0; clr_cnt = 1'b0;
    hit = 0;
    if (l) begin
      m_pat2 = p; q2.delete();
    end else if (e) begin
      q2.push_back(d);
      if (q2.size() > 2) void'(q2.pop_front());
      v = '0;
      for (int i = 0; i < q2.size(); i++) v = {v[14:0], q2[i]};
      hit = (q2.size() == 2) && (v[1:0] == m_pat2);
      if (hit && !overlap2) q2.delete();
    end
    m_dout2 = hit;
    if (c) begin
      m_cnt2 = 0; m_sat2 = 0;
    end else if (hit) begin
      if (m_cnt2 < 3) m_cnt2++; else m_sat2 = 1;
    end
    @(posedge clk); #1;
    chk({tag, "_dout2"}, 32'(dout2), 32'(m_dout2));
    chk({tag, "_cnt2"}, 32'(cnt2), 32'(m_cnt2));
    chk({tag, "_sat2"}, 32'(sat2), 32'(m_sat2));
  endtask

  initial begin
    logic [3:0] rp;
    // ---------------- reset ----------------
    #12;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_sat", 32'(cnt_sat), 32'd0);
    chk("rst_cnt2", 32'(cnt2), 32'd0);
    @(negedge clk); rst = 1'b0;
    model_reset();

    // ---------------- overlapping 1011011 ----------------
    overlap = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step1(1, s7[i], 0, 4'b0, 0, "ov");
      chk("ov_pulse", 32'(dout), 32'((i == 3) || (i == 6)));
    end
    chk("ov_total", 32'(match_cnt), 32'd2);
    step1(0, 0, 1, 4'b1011, 1, "rearm1");

    // ---------------- non-overlapping 1011011 ----------------
    overlap = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step1(1, s7[i], 0, 4'b0, 0, "nov");
      chk("nov_pulse", 32'(dout), 32'(i == 3));
    end
    chk("nov_total", 32'(match_cnt), 32'd1);
    step1(0, 0, 1, 4'b1011, 1, "rearm2");

    // ---------------- en gaps ----------------
    overlap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step1(1, s4[i], 0, 4'b0, 0, "gap_bit");
      chk("gap_pulse", 32'(dout), 32'(i == 3));
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          step1(0, 1, 0, 4'b0, 0, "gap_idle");
          chk("gap_idle_low", 32'(dout), 32'd0);
        end
      end
    end
    chk("gap_total", 32'(match_cnt), 32'd1);

    // ---------------- load mid-stream ----------------
    step1(1, 1, 0, 4'b0, 0, "ld_pre");
    step1(1, 0, 0, 4'b0, 0, "ld_pre");
    chk("ld_pre_low", 32'(dout), 32'd0);
    step1(1, 1, 1, 4'b0110, 0, "ld_edge");
    for (int i = 0; i < 4; i++) begin
      step1(1, s0110[i], 0, 4'b0, 0, "ld_post");
      chk("ld_post_pulse", 32'(dout), 32'(i == 3));
    end
    chk("ld_total", 32'(match_cnt), 32'd2);

    // ---------------- async reset between edges ----------------
    #2;
    en = 1'b0; load = 1'b0; clr_cnt = 1'b0;
    en2 = 1'b0; load2 = 1'b0; clr2 = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_cnt", 32'(match_cnt), 32'd0);
    chk("arst_sat", 32'(cnt_sat), 32'd0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    step1(1, 0, 0, 4'b0, 0, "arst_post");
    step1(1, 1, 0, 4'b0, 0, "arst_post");
    step1(1, 1, 0, 4'b0, 0, "arst_post");
    chk("arst_no_pulse", 32'(dout), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step1(1, s4[i], 0, 4'b0, 0, "arst_pat");
      chk("arst_pat_pulse", 32'(dout), 32'(i == 3));
    end

    // ---------------- saturation on small instance ----------------
    overlap2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step2(1, 1, 0, 2'b0, 0, "sat");
      chk("sat_pulse", 32'(dout2), 32'(i >= 1));
      chk("sat_cnt", 32'(cnt2), 32'((i > 3) ? 3 : i));
      chk("sat_flag", 32'(sat2), 32'(i >= 4));
    end
    step2(1, 1, 0, 2'b0, 1, "satclr");
    chk("satclr_hit", 32'(dout2), 32'd1);
    chk("satclr_cnt", 32'(cnt2), 32'd0);
    chk("satclr_flag", 32'(sat2), 32'd0);

    // ---------------- random traffic ----------------
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 29) == 0) overlap = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0:       rp = 4'($urandom);
        1:       rp = 4'b0000;
        default: rp = 4'b1111;
      endcase
      step1($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 39) == 0,
            rp, $urandom_range(0, 59) == 0, "rnd1");
    end
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 29) == 0) overlap2 = $urandom_range(0, 1);
      step2($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 39) == 0,
            2'($urandom), $urandom_range(0, 79) == 0, "rnd2");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector, the next generation of the fixed 4-bit sequence-detector FSM. Watches a 1-bit serial stream and pulses `dout` when the last `PAT_W` enabled bits equal a run-time-loadable pattern. It also supports overlapping/non-overlapping detection, an input qualifier and a saturating match counter. Sits directly on a serial data line, with the pattern and counter accessed from a control register bank.

## Interface
Parameters:
- `PAT_W`, 4: pattern length in bits, legal range 2..16.
- `CNT_W`, 8: match counter width, legal range 1..16.
- `RST_PAT`, 4'b1011: pattern register value after reset, `PAT_W` bits. Compared MSB-first: the MSB is the oldest bit.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `en`, in, 1: `din` is sampled only on cycles where `en`=1.
- `din`, in, 1: serial data bit.
- `load`, in, 1: capture `pat_in` into the pattern register.
- `pat_in`, in, `PAT_W`: new pattern value.
- `overlap`, in, 1: 1 = overlapping detection; 0 = non-overlapping.
- `clr_cnt`, in, 1: synchronous clear of `match_cnt` and `cnt_sat`.
- `dout`, out, 1: one-cycle match pulse, registered.
- `match_cnt`, out, `CNT_W`: number of matches, saturating.
- `cnt_sat`, out, 1: sticky flag, set when `match_cnt` saturates.

## Operation
Internal state:
- `pat`: pattern register, `PAT_W` bits.
- `hist`: history shift register, `PAT_W` bits; the newest bit enters at the LSB.
- `fill`: count of valid history bits, 0..`PAT_W`, saturating at `PAT_W`.
- Two control states:
  - IDLE: `fill` < `PAT_W`.
  - ARMED: `fill` = `PAT_W`.

Reset (async, immediate) sets:
- `pat`=`RST_PAT`, `hist`=0, `fill`=0
- `dout`=0, `match_cnt`=0, `cnt_sat`=0

Per rising edge, in this priority order:
1. `load`=1:
   - `pat`←`pat_in`, `hist`←0, `fill`←0, `dout`←0.
   - `din` and `en` are ignored this cycle.
   - Counter is unaffected, unless `clr_cnt` is also 1.
2. Else if `en`=1, compute:
   - `h'` = {`hist`[PAT_W-2:0], `din`}
   - `f'` = min(`fill`+1, `PAT_W`)
   - `hit` = (`f'`==`PAT_W`) && (`h'`==`pat`)
   - Register updates:
     - `hist`←`h'`
     - `dout`←`hit`
     - if `hit` and `overlap`=0: `fill`←0. The history is retained but invalidated, so a new match needs `PAT_W` fresh bits.
     - otherwise: `fill`←`f'`
3. Else (`en`=0): `hist` and `fill` hold, `dout`←0.

Counter, evaluated every edge:
- `clr_cnt`=1: `match_cnt`←0 and `cnt_sat`←0. Clear wins over a simultaneous hit, so that hit is not counted.
- Else if `hit`:
  - If `match_cnt` < 2^CNT_W−1: increment by 1.
  - At 2^CNT_W−1: hold and set `cnt_sat`.

Other rules:
- A change of `overlap` takes effect on the next enabled bit. No flush.
- The block is legal with `pat_in` equal to all zeros or all ones.

## Timing
- Latency: the edge that samples the completing `din` (with `en`=1) raises `dout`. `dout` is high for exactly that one cycle, and `match_cnt` updates on the same edge.
- Back-to-back matches:
  - Overlapping mode allows consecutive `dout` pulses, for example pattern 11 on stream 111.
  - Non-overlapping mode: minimum `PAT_W` enabled bits between pulses.
- `en` gaps are transparent: the pattern may span gap cycles.
- Reset asserted mid-stream: all outputs go to their reset values immediately. The first possible `dout` comes on the `PAT_W`-th enabled bit after reset deasserts.
- `load` mid-stream discards partial progress. The first possible match with the new pattern is `PAT_W` enabled bits after the load edge.

## Test plan
- Defaults (`PAT_W`=4, pattern 1011), `overlap`=1, stream 1,0,1,1,0,1,1 with `en`=1 → `dout` pulses after bits 4 and 7; `match_cnt`=2.
- Same stream with `overlap`=0 → single pulse after bit 4, none after bit 7; `match_cnt`=1.
- Stream 1,0,1,1 with `en` deasserted for 3 cycles between each pair of bits → one pulse on the edge sampling the final 1; `dout`=0 on all gap cycles.
- `load` with `pat_in`=0110 asserted after bits 1,0 of 1011, then stream 0,1,1,0 → no pulse before the load, one pulse on the 4th bit after the load.
- `CNT_W`=2, pattern 11, `overlap`=1, six consecutive 1s:
  - 5 hits occur; `match_cnt` stops at 3 with `cnt_sat`=1.
  - Then `clr_cnt` coincident with a hit → `match_cnt`=0, `cnt_sat`=0.
- Assert `rst` asynchronously between clock edges mid-pattern → `dout`, `match_cnt`, `cnt_sat` go to 0 before the next edge and `pat` returns to 1011. Stream 0,1,1 after release gives no pulse.
